// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: the command codes
// produced by the priority decoder and the return-stack counter width.
package pc_seq_pkg;

   // Command selected by the priority decoder for the current cycle
   typedef logic [1:0] cmd_t;

   localparam cmd_t CMD_INC  = 2'd0;
   localparam cmd_t CMD_LD   = 2'd1;
   localparam cmd_t CMD_CALL = 2'd2;
   localparam cmd_t CMD_RET  = 2'd3;

   // Counter width for a stack of depth entries.
   // One extra bit is needed so that "full" (cnt == depth) can be represented.
   function automatic int rasCntWidth(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: a LIFO register array whose write pointer is the
// valid-entry count. Pushes into a full stack and pops from an empty stack
// are ignored here; the caller decides what those cases mean for the PC.
// Entry contents are not reset, because only the count defines validity.
module pc_ras
   import pc_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 10
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic                          pop,
   input  logic [W-1:0]                  push_data,
   output logic [W-1:0]                  top_data,
   output logic [rasCntWidth(DEPTH)-1:0] cnt,
   output logic                          full,
   output logic                          empty
);

   localparam int CW = rasCntWidth(DEPTH);
   localparam int AW = $clog2(DEPTH);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [W-1:0]  stack_q [DEPTH];
   logic [AW-1:0] wrIdx;
   logic [AW-1:0] topIdx;
   logic          pushOk;
   logic          popOk;

   // Full and empty come straight from the registered count.
   // DEPTH is a power of two, so the low count bits index the next free slot
   // and one below that is the top entry (also correct when full, via wrap).
   assign full     = (cnt_q == CW'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign wrIdx    = cnt_q[AW-1:0];
   assign topIdx   = wrIdx - AW'(1);
   assign top_data = stack_q[topIdx];
   assign cnt      = cnt_q;

   // Push has precedence over pop if both ever arrive together
   assign pushOk = push & ~full;
   assign popOk  = pop & ~empty & ~push;

   // Next count: grows on an accepted push, shrinks on an accepted pop
   always_comb begin
      cnt_d = cnt_q;
      if (pushOk) begin
         cnt_d = cnt_q + CW'(1);
      end else if (popOk) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Count register; reset empties the stack regardless of its contents
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Storage array; only the slot at the current count is written on a push
   always_ff @(posedge clk) begin
      if (pushOk) begin
         stack_q[wrIdx] <= push_data;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with stall, absolute load, call/return through
// an internal return-address stack, and configurable reset vector and step.
// Optional build macro: PC_SEQ_TRAP_EN adds a trap output; stack overflow and
// underflow then redirect the PC to TRAP_VEC with a one-cycle trap pulse.
// Without it, an overflowing call still jumps (the push is dropped) and an
// underflowing return behaves as a plain increment.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int          PC_W      = 10,
   parameter int unsigned STEP      = 1,
   parameter int unsigned RESET_VEC = 0,
   parameter int          RAS_DEPTH = 4,
   parameter int unsigned TRAP_VEC  = 1023
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              en,
   input  logic                              ld_en,
   input  logic [PC_W-1:0]                   ld_addr,
   input  logic                              call_en,
   input  logic [PC_W-1:0]                   call_addr,
   input  logic                              ret_en,
   output logic [PC_W-1:0]                   pc_out,
   output logic [rasCntWidth(RAS_DEPTH)-1:0] ras_cnt,
   output logic                              ras_full,
   output logic                              ras_empty
`ifdef PC_SEQ_TRAP_EN
   ,
   output logic                              trap
`endif
);

   localparam int CW = rasCntWidth(RAS_DEPTH);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [PC_W-1:0] pcInc;
   logic [PC_W-1:0] topData;
   logic            rasPush;
   logic            rasPop;
   logic            rasFull;
   logic            rasEmpty;
   logic [CW-1:0]   rasCnt;
   cmd_t            cmd;
`ifdef PC_SEQ_TRAP_EN
   logic            trap_q;
   logic            trap_d;
`endif

   // Sequential successor address; also the return address pushed on a call.
   // Wrap past the top of the address space is silent.
   assign pcInc = pc_q + PC_W'(STEP);

   pc_ras #(
      .DEPTH (RAS_DEPTH),
      .W     (PC_W)
   ) uRas (
      .clk       (clk),
      .reset     (reset),
      .push      (rasPush),
      .pop       (rasPop),
      .push_data (pcInc),
      .top_data  (topData),
      .cnt       (rasCnt),
      .full      (rasFull),
      .empty     (rasEmpty)
   );

   // Priority decoder: load beats call beats return beats plain increment
   always_comb begin
      cmd = CMD_INC;
      if (ld_en) begin
         cmd = CMD_LD;
      end else if (call_en) begin
         cmd = CMD_CALL;
      end else if (ret_en) begin
         cmd = CMD_RET;
      end
   end

   // Next-PC mux and stack requests; nothing changes while stalled
   always_comb begin
      pc_d    = pc_q;
      rasPush = 1'b0;
      rasPop  = 1'b0;
`ifdef PC_SEQ_TRAP_EN
      trap_d  = 1'b0;
`endif
      if (en) begin
         case (cmd)
            CMD_LD: begin
               pc_d = ld_addr;
            end
            CMD_CALL: begin
               if (!rasFull) begin
                  rasPush = 1'b1;
                  pc_d    = call_addr;
               end else begin
`ifdef PC_SEQ_TRAP_EN
                  pc_d   = PC_W'(TRAP_VEC);
                  trap_d = 1'b1;
`else
                  pc_d   = call_addr;
`endif
               end
            end
            CMD_RET: begin
               if (!rasEmpty) begin
                  rasPop = 1'b1;
                  pc_d   = topData;
               end else begin
`ifdef PC_SEQ_TRAP_EN
                  pc_d   = PC_W'(TRAP_VEC);
                  trap_d = 1'b1;
`else
                  pc_d   = pcInc;
`endif
               end
            end
            default: begin
               pc_d = pcInc;
            end
         endcase
      end
   end

   // PC register; reset returns to the configured reset vector
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= PC_W'(RESET_VEC);
      end else begin
         pc_q <= pc_d;
      end
   end

`ifdef PC_SEQ_TRAP_EN
   // Trap pulse is registered so it lines up with the PC entering TRAP_VEC
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trap_q <= 1'b0;
      end else begin
         trap_q <= trap_d;
      end
   end

   assign trap = trap_q;
`endif

   assign pc_out    = pc_q;
   assign ras_cnt   = rasCnt;
   assign ras_full  = rasFull;
   assign ras_empty = rasEmpty;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: a directed vector table, a hand-written
// asynchronous reset sequence, and randomized traffic against a queue-based
// reference model. Honours PC_SEQ_TRAP_EN for expected overflow behaviour.
module tb_pc_sequencer;

   localparam int PC_W      = 10;
   localparam int STEP      = 1;
   localparam int RESET_VEC = 0;
   localparam int RAS_DEPTH = 4;
   localparam int TRAP_VEC  = 1023;
   localparam int CW        = $clog2(RAS_DEPTH) + 1;
   localparam int PC_MOD    = 1 << PC_W;

`ifdef PC_SEQ_TRAP_EN
   localparam int  OVF_PC   = TRAP_VEC;
   localparam int  UNF_PC   = TRAP_VEC;
   localparam logic ERR_TRAP = 1'b1;
`else
   localparam int  OVF_PC   = 60;
   localparam int  UNF_PC   = 8;
   localparam logic ERR_TRAP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            en;
   logic            ld_en;
   logic [PC_W-1:0] ld_addr;
   logic            call_en;
   logic [PC_W-1:0] call_addr;
   logic            ret_en;
   logic [PC_W-1:0] pc_out;
   logic [CW-1:0]   ras_cnt;
   logic            ras_full;
   logic            ras_empty;
   logic            trapObs;

   int nChecks = 0;
   int nFails  = 0;

   typedef struct {
      logic en;
      logic ld;
      int   ldAddr;
      logic call;
      int   callAddr;
      logic ret;
      int   expPc;
      int   expCnt;
      logic expTrap;
   } vec_t;

   vec_t vecs[$];

   // Reference model state: PC as an integer and the stack as a queue
   int modelPc;
   int modelStack[$];
   logic modelTrap;

   always #5 clk = ~clk;

   pc_sequencer #(
      .PC_W      (PC_W),
      .STEP      (STEP),
      .RESET_VEC (RESET_VEC),
      .RAS_DEPTH (RAS_DEPTH),
      .TRAP_VEC  (TRAP_VEC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .call_en   (call_en),
      .call_addr (call_addr),
      .ret_en    (ret_en),
      .pc_out    (pc_out),
      .ras_cnt   (ras_cnt),
      .ras_full  (ras_full),
      .ras_empty (ras_empty)
`ifdef PC_SEQ_TRAP_EN
      ,
      .trap      (trapObs)
`endif
   );

`ifndef PC_SEQ_TRAP_EN
   assign trapObs = 1'b0;
`endif

   function automatic vec_t mkVec(logic e, logic l, int la, logic c, int ca,
                                  logic r, int ep, int ec, logic et);
      vec_t v;
      v.en = e; v.ld = l; v.ldAddr = la; v.call = c; v.callAddr = ca;
      v.ret = r; v.expPc = ep; v.expCnt = ec; v.expTrap = et;
      return v;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic l, input int la,
                                input logic c, input int ca, input logic r);
      en        = e;
      ld_en     = l;
      ld_addr   = PC_W'(la);
      call_en   = c;
      call_addr = PC_W'(ca);
      ret_en    = r;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkAll(input string tag, input int ePc, input int eCnt, input logic eTrap);
      checkOutput({tag, " pc"},    int'(pc_out),    ePc);
      checkOutput({tag, " cnt"},   int'(ras_cnt),   eCnt);
      checkOutput({tag, " full"},  int'(ras_full),  int'(eCnt == RAS_DEPTH));
      checkOutput({tag, " empty"}, int'(ras_empty), int'(eCnt == 0));
`ifdef PC_SEQ_TRAP_EN
      checkOutput({tag, " trap"},  int'(trapObs),   int'(eTrap));
`else
      if (eTrap) checkOutput({tag, " trap"}, 0, 1);
`endif
   endtask

   // Behavioural reference: one clock of the documented command rules
   task automatic modelStep(input logic e, input logic l, input int la,
                            input logic c, input int ca, input logic r);
      modelTrap = 1'b0;
      if (!e) return;
      if (l) begin
         modelPc = la;
      end else if (c) begin
         if (modelStack.size() < RAS_DEPTH) begin
            modelStack.push_back((modelPc + STEP) % PC_MOD);
            modelPc = ca;
         end else begin
`ifdef PC_SEQ_TRAP_EN
            modelPc = TRAP_VEC; modelTrap = 1'b1;
`else
            modelPc = ca;
`endif
         end
      end else if (r) begin
         if (modelStack.size() > 0) begin
            modelPc = modelStack.pop_back();
         end else begin
`ifdef PC_SEQ_TRAP_EN
            modelPc = TRAP_VEC; modelTrap = 1'b1;
`else
            modelPc = (modelPc + STEP) % PC_MOD;
`endif
         end
      end else begin
         modelPc = (modelPc + STEP) % PC_MOD;
      end
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      reset = 1'b1;
      stepCycle();
      stepCycle();
      reset = 1'b0;
      modelPc = RESET_VEC;
      modelStack.delete();
      modelTrap = 1'b0;
   endtask

   initial begin
      int e, l, la, c, ca, r;
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
      #2;
      checkAll("reset", RESET_VEC, 0, 1'b0);
      doReset();
      checkAll("post-reset", 0, 0, 1'b0);

      // Directed sequence: {en, ld, ldAddr, call, callAddr, ret, expPc, expCnt, expTrap}
      for (int i = 1; i <= 5; i++) vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, i, 0, 0));
      vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 5, 0, 0));
      vecs.push_back(mkVec(0, 1, 77, 1, 88, 0, 5, 0, 0));
      vecs.push_back(mkVec(0, 0, 0, 0, 0, 1, 5, 0, 0));
      vecs.push_back(mkVec(1, 1, 1022, 0, 0, 0, 1022, 0, 0));
      vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 1023, 0, 0));
      vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mkVec(1, 1, 10, 0, 0, 0, 10, 0, 0));
      vecs.push_back(mkVec(1, 0, 0, 1, 100, 0, 100, 1, 0));
      vecs.push_back(mkVec(1, 0, 0, 0, 0, 1, 11, 0, 0));
      vecs.push_back(mkVec(1, 1, 5, 0, 0, 0, 5, 0, 0));
      vecs.push_back(mkVec(1, 0, 0, 1, 20, 0, 20, 1, 0));
      vecs.push_back(mkVec(1, 0, 0, 1, 30, 0, 30, 2, 0));
      vecs.push_back(mkVec(1, 0, 0, 1, 40, 0, 40, 3, 0));
      vecs.push_back(mkVec(1, 0, 0, 1, 50, 0, 50, 4, 0));
      vecs.push_back(mkVec(1, 0, 0, 1, 60, 0, OVF_PC, 4, ERR_TRAP));
      vecs.push_back(mkVec(1, 0, 0, 0, 0, 1, 41, 3, 0));
      vecs.push_back(mkVec(1, 0, 0, 0, 0, 1, 31, 2, 0));
      vecs.push_back(mkVec(1, 0, 0, 0, 0, 1, 21, 1, 0));
      vecs.push_back(mkVec(1, 0, 0, 0, 0, 1, 6, 0, 0));
      vecs.push_back(mkVec(1, 1, 7, 0, 0, 0, 7, 0, 0));
      vecs.push_back(mkVec(1, 0, 0, 0, 0, 1, UNF_PC, 0, ERR_TRAP));
      vecs.push_back(mkVec(1, 1, 200, 1, 300, 0, 200, 0, 0));
      vecs.push_back(mkVec(1, 0, 0, 1, 400, 1, 400, 1, 0));
      vecs.push_back(mkVec(1, 1, 500, 0, 0, 1, 500, 1, 0));
      vecs.push_back(mkVec(1, 0, 0, 0, 0, 0, 501, 1, 0));
      vecs.push_back(mkVec(0, 0, 0, 0, 0, 1, 501, 1, 0));
      vecs.push_back(mkVec(1, 0, 0, 0, 0, 1, 201, 0, 0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].en, vecs[i].ld, vecs[i].ldAddr,
                       vecs[i].call, vecs[i].callAddr, vecs[i].ret);
         stepCycle();
         checkAll($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expCnt, vecs[i].expTrap);
      end

      // Asynchronous reset in the middle of a call sequence
      applyStimulus(1, 1, 10, 0, 0, 0);
      stepCycle();
      applyStimulus(1, 0, 0, 1, 100, 0);
      stepCycle();
      checkAll("pre-async", 100, 1, 1'b0);
      applyStimulus(1, 0, 0, 1, 150, 0);
      #2;
      reset = 1'b1;
      #1;
      checkAll("async-reset", 0, 0, 1'b0);
      @(posedge clk);
      #1;
      checkAll("reset-held", 0, 0, 1'b0);
      reset = 1'b0;
      applyStimulus(1, 0, 0, 0, 0, 1);
      stepCycle();
      checkAll("after-release", UNF_PC == TRAP_VEC ? TRAP_VEC : 1, 0, ERR_TRAP);

      // Randomized traffic against the reference model
      doReset();
      for (int n = 0; n < 1500; n++) begin
         e  = ($urandom_range(0, 9) < 8) ? 1 : 0;
         l  = ($urandom_range(0, 9) == 0) ? 1 : 0;
         la = $urandom_range(0, PC_MOD - 1);
         c  = ($urandom_range(0, 3) == 0) ? 1 : 0;
         ca = $urandom_range(0, PC_MOD - 1);
         r  = ($urandom_range(0, 3) == 0) ? 1 : 0;
         applyStimulus(e[0], l[0], la, c[0], ca, r[0]);
         modelStep(e[0], l[0], la, c[0], ca, r[0]);
         stepCycle();
         checkAll($sformatf("rand%0d", n), modelPc, modelStack.size(), modelTrap);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
